// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Single-cycle handshake: a request completes in any cycle where imem_req && imem_ready.
interface fetch_decode_stage_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch front end with IF/ID decode slot, one-entry skid buffer and
// branch redirect driven back from the control logic.
module fetch_decode_stage #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_decode_stage_if.master      imem,
  input  logic                      stall,
  input  logic                      BrTaken,
  input  logic                      UncondBr,
  output logic [31:0]               instr,
  output logic [10:0]               OpCode,
  output logic [ADDR_W-1:0]         instr_pc,
  output logic                      instr_valid,
  output logic                      redirect
);

  typedef enum logic [0:0] {StFetch, StSkid} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;

  logic              adv;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_uncond;
  logic [ADDR_W-1:0] off_cond;
  logic [ADDR_W-1:0] br_target;

  // Gating with valid_q keeps X on BrTaken from leaking out while the slot is empty.
  assign redirect = valid_q & BrTaken & ~stall;
  assign adv      = ~valid_q | ~stall;
  assign pc_inc   = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};

  assign off_uncond = {{(ADDR_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
  assign off_cond   = {{(ADDR_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};
  assign br_target  = instr_pc_q + (UncondBr ? off_uncond : off_cond);

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign OpCode      = valid_q ? instr_q[31:21] : 11'd0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (redirect) begin
      // Any word returned this cycle is from the wrong path and is dropped.
      pc_d        = br_target;
      valid_d     = 1'b0;
      buf_instr_d = '0;
      buf_pc_d    = '0;
      state_d     = StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem.imem_ready) begin
            pc_d = pc_inc;
            if (adv) begin
              instr_d    = imem.imem_rdata;
              instr_pc_d = pc_q;
              valid_d    = 1'b1;
            end else begin
              // Slot is stalled: park the returned word and stop requesting.
              buf_instr_d = imem.imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = StSkid;
            end
          end else if (adv) begin
            valid_d = 1'b0;
          end
        end
        StSkid: begin
          if (!stall) begin
            instr_d    = buf_instr_q;
            instr_pc_d = buf_pc_q;
            valid_d    = 1'b1;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
